// File: rtl/clk_gate_ctrl.sv
// Per-channel idle-detect clock-gating sequencer: counts idle cycles, handshakes
// a sleep request with the peripheral, gates its clock and re-enables it on wake.
module clk_gate_ctrl #(
    parameter int CH_NUM   = 4,
    parameter int CNT_W    = 8,
    parameter int WAKE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              global_gate_en,
    input  logic              pad_yy_test_mode,
    input  logic [CNT_W-1:0]  idle_thresh,
    input  logic [CH_NUM-1:0] ch_busy,
    input  logic [CH_NUM-1:0] ch_wake_req,
    input  logic [CH_NUM-1:0] ch_sleep_ack,
    output logic [CH_NUM-1:0] ch_sleep_req,
    output logic [CH_NUM-1:0] ch_module_en,
    output logic [CH_NUM-1:0] ch_ready,
    output logic [CH_NUM-1:0] ch_gated
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        REQ  = 2'd1,
        OFF  = 2'd2,
        WAKE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYC - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        return (val == {CNT_W{1'b1}}) ? val : val + CNT_W'(1);
    endfunction

    logic             inhibit;
    logic [CNT_W-1:0] thresh_last;

    // idle_thresh==0 wraps thresh_last to all-ones, but inhibit already blocks gating then.
    assign inhibit     = !global_gate_en || pad_yy_test_mode || (idle_thresh == '0);
    assign thresh_last = idle_thresh - CNT_W'(1);

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        state_t           state;
        state_t           state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             active;

        assign active = ch_busy[i] || ch_wake_req[i];

        always_ff @(posedge clk or negedge rst_b) begin
            if (!rst_b) begin
                state <= RUN;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end

        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            case (state)
                RUN: begin
                    if (active) begin
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = sat_inc(cnt);
                        if (!inhibit && (cnt == thresh_last)) state_nxt = REQ;
                    end
                end
                REQ: begin
                    // Abort wins over a simultaneous acknowledge.
                    if (active || inhibit) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end else if (ch_sleep_ack[i]) begin
                        state_nxt = OFF;
                    end
                end
                OFF: begin
                    if (active || inhibit) begin
                        state_nxt = WAKE;
                        cnt_nxt   = '0;
                    end
                end
                WAKE: begin
                    if (cnt == WAKE_LAST) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end

        assign ch_module_en[i] = (state != OFF) || pad_yy_test_mode;
        assign ch_ready[i]     = (state == RUN);
        assign ch_sleep_req[i] = (state == REQ);
        assign ch_gated[i]     = (state == OFF);
    end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl: idle-to-gate, wake settle, abort priority,
// test mode, asynchronous reset and inhibit paths.
module tb_clk_gate_ctrl;

    localparam int CH_NUM = 4;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              rst_b;
    logic              global_gate_en;
    logic              pad_yy_test_mode;
    logic [CNT_W-1:0]  idle_thresh;
    logic [CH_NUM-1:0] ch_busy;
    logic [CH_NUM-1:0] ch_wake_req;
    logic [CH_NUM-1:0] ch_sleep_ack;
    logic [CH_NUM-1:0] ch_sleep_req;
    logic [CH_NUM-1:0] ch_module_en;
    logic [CH_NUM-1:0] ch_ready;
    logic [CH_NUM-1:0] ch_gated;

    int errors = 0;
    int checks = 0;

    clk_gate_ctrl #(.CH_NUM(CH_NUM), .CNT_W(CNT_W), .WAKE_CYC(4)) dut (
        .clk              (clk),
        .rst_b            (rst_b),
        .global_gate_en   (global_gate_en),
        .pad_yy_test_mode (pad_yy_test_mode),
        .idle_thresh      (idle_thresh),
        .ch_busy          (ch_busy),
        .ch_wake_req      (ch_wake_req),
        .ch_sleep_ack     (ch_sleep_ack),
        .ch_sleep_req     (ch_sleep_req),
        .ch_module_en     (ch_module_en),
        .ch_ready         (ch_ready),
        .ch_gated         (ch_gated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [CH_NUM-1:0] got,
                         input logic [CH_NUM-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [CH_NUM-1:0] en,
                             input logic [CH_NUM-1:0] rdy, input logic [CH_NUM-1:0] req,
                             input logic [CH_NUM-1:0] gtd);
        check({tag, ".module_en"}, ch_module_en, en);
        check({tag, ".ready"},     ch_ready,     rdy);
        check({tag, ".sleep_req"}, ch_sleep_req, req);
        check({tag, ".gated"},     ch_gated,     gtd);
    endtask

    initial begin
        rst_b            = 1'b0;
        global_gate_en   = 1'b1;
        pad_yy_test_mode = 1'b0;
        idle_thresh      = 8'd5;
        ch_busy          = 4'b1110;
        ch_wake_req      = 4'b0000;
        ch_sleep_ack     = 4'b0000;
        #12;
        check_all("reset", 4'b1111, 4'b1111, 4'b0000, 4'b0000);
        @(negedge clk);
        rst_b = 1'b1;
        #1;

        // 1: five idle cycles on ch0 raise sleep_req, ack gates it
        step(4);
        check("t1.req_after4", ch_sleep_req, 4'b0000);
        step(1);
        check_all("t1.req_after5", 4'b1111, 4'b1110, 4'b0001, 4'b0000);
        ch_sleep_ack = 4'b0001;
        step(1);
        ch_sleep_ack = 4'b0000;
        check_all("t1.off", 4'b1110, 4'b1110, 4'b0000, 4'b0001);

        // 2: one-cycle wake pulse, four-cycle settle window
        ch_wake_req = 4'b0001;
        step(1);
        ch_wake_req = 4'b0000;
        check_all("t2.wake0", 4'b1111, 4'b1110, 4'b0000, 4'b0000);
        for (int k = 1; k < 4; k++) begin
            step(1);
            check($sformatf("t2.wake%0d.ready", k), ch_ready, 4'b1110);
        end
        step(1);
        check("t2.ready", ch_ready, 4'b1111);

        // 3: busy and ack together in REQ abort back to RUN, counter restarts
        step(5);
        check("t3.req", ch_sleep_req, 4'b0001);
        ch_busy      = 4'b1111;
        ch_sleep_ack = 4'b0001;
        step(1);
        ch_busy      = 4'b1110;
        ch_sleep_ack = 4'b0000;
        check_all("t3.abort", 4'b1111, 4'b1111, 4'b0000, 4'b0000);
        step(4);
        check("t3.restart4", ch_sleep_req, 4'b0000);
        step(1);
        check("t3.restart5", ch_sleep_req, 4'b0001);
        ch_sleep_ack = 4'b0001;
        step(1);
        ch_sleep_ack = 4'b0000;
        check("t3.off", ch_gated, 4'b0001);

        // 4: test mode forces module_en at once and wakes the channel
        @(negedge clk);
        pad_yy_test_mode = 1'b1;
        #1;
        check("t4.en_comb", ch_module_en, 4'b1111);
        check("t4.still_gated", ch_gated, 4'b0001);
        step(1);
        check_all("t4.wake", 4'b1111, 4'b1110, 4'b0000, 4'b0000);
        idle_thresh = 8'd1;
        for (int k = 0; k < 10; k++) begin
            step(1);
            check($sformatf("t4.noreq%0d", k), ch_sleep_req, 4'b0000);
        end
        check("t4.ready", ch_ready, 4'b1111);
        pad_yy_test_mode = 1'b0;

        // 5: ch1 gated, ch2 in REQ, then asynchronous reset mid-cycle
        ch_busy = 4'b1111;
        step(1);
        ch_busy = 4'b1001;
        step(1);
        check("t5.req", ch_sleep_req, 4'b0110);
        ch_sleep_ack = 4'b0010;
        step(1);
        check_all("t5.pre", 4'b1101, 4'b1001, 4'b0100, 4'b0010);
        #3;
        rst_b = 1'b0;
        #1;
        check_all("t5.reset", 4'b1111, 4'b1111, 4'b0000, 4'b0000);
        ch_sleep_ack = 4'b0000;
        ch_busy      = 4'b0000;
        idle_thresh  = 8'd0;
        #2;
        rst_b = 1'b1;

        // 6: idle_thresh=0 never requests sleep
        for (int k = 0; k < 300; k++) begin
            step(1);
            check($sformatf("t6.thresh0_%0d", k), ch_sleep_req, 4'b0000);
        end

        // 6b: gate all channels, then global_gate_en=0 wakes them and blocks re-gating
        idle_thresh = 8'd2;
        ch_busy     = 4'b1111;
        step(1);
        ch_busy = 4'b0000;
        step(1);
        check("t6.req_pre1", ch_sleep_req, 4'b0000);
        step(1);
        check("t6.req_all", ch_sleep_req, 4'b1111);
        ch_sleep_ack = 4'b1111;
        step(1);
        ch_sleep_ack = 4'b0000;
        check_all("t6.off_all", 4'b0000, 4'b0000, 4'b0000, 4'b1111);
        global_gate_en = 1'b0;
        step(1);
        check_all("t6.wake_all", 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        for (int k = 0; k < 300; k++) begin
            step(1);
            check($sformatf("t6.gate_off_%0d", k), ch_sleep_req, 4'b0000);
        end
        check_all("t6.final", 4'b1111, 4'b1111, 4'b0000, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
